mdio_responder: RTL and testbench

PHY-side MDIO management responder: the slave end of the MDC/MDIO bus that the Ethernet framing block drives by bit-banging. It decodes IEEE 802.3 Clause 22 frames, serves reads and writes to a 32 x 16-bit PHY register file, and drives MDIO back during read turnaround and data. It lives beside the framing block in the Ethernet subsystem as a loopback/simulation PHY model and as an on-chip management target.

---
 rtl/mdio_pkg.sv | 47 ++++
 rtl/mdio_sync_edge.sv | 30 +++
 rtl/mdio_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO responder.
// Optional build macro used by the top: MDIO_RESP_BROADCAST_EN.
package mdio_pkg;

  localparam int unsigned PRE_LEN  = 32;
  localparam int unsigned PRE_W    = 6;
  localparam int unsigned BIT_W    = 5;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [2:0] {
    S_PRE   = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [REG_AW-1:0] REG_BMCR = 5'd0;
  localparam logic [REG_AW-1:0] REG_BMSR = 5'd1;
  localparam logic [REG_AW-1:0] REG_ID1  = 5'd2;
  localparam logic [REG_AW-1:0] REG_ID2  = 5'd3;

  localparam logic [DATA_W-1:0] BMCR_RESET = 16'h3100;
  localparam logic [DATA_W-1:0] BMSR_BASE  = 16'h7809;

  // Write commit payload handed from the frame decoder to the register file
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } mdio_wr_t;

  function automatic logic reg_writable(input logic [REG_AW-1:0] a);
    return (a == REG_BMCR) || (a > REG_ID2);
  endfunction

  function automatic logic [DATA_W-1:0] reg_reset_val(input logic [REG_AW-1:0] a);
    return (a == REG_BMCR) ? BMCR_RESET : 16'h0000;
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses (3 cycles pin-to-pulse).
module mdio_sync_edge (
  input  logic msoc_clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
      rise <= q & ~prev;
      fall <= ~q & prev;
    end
  end

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause 22 MDIO responder with a 32 x 16 register file.
// Build option: MDIO_RESP_BROADCAST_EN lets PHYAD 0 match writes.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter logic [15:0] PHY_ID1  = 16'h0007,
  parameter logic [15:0] PHY_ID2  = 16'hC0F1,
  parameter int unsigned MIN_HALF = 3
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        oe_mdio,
  input  logic        i_link_up,
  output logic        o_wr_strobe,
  output logic [4:0]  o_wr_addr,
  output logic [15:0] o_wr_data
);

  logic mdc_rise, mdc_fall, mdc_lvl_unused;
  logic mdio_s, mdio_rise_unused, mdio_fall_unused;

  mdio_sync_edge u_mdc_sync (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .d        (i_mdc),
    .q        (mdc_lvl_unused),
    .rise     (mdc_rise),
    .fall     (mdc_fall)
  );

  mdio_sync_edge u_mdio_sync (
    .msoc_clk (msoc_clk),
    .rstn     (rstn),
    .d        (i_mdio),
    .q        (mdio_s),
    .rise     (mdio_rise_unused),
    .fall     (mdio_fall_unused)
  );

  mdio_state_e       state, state_n;
  logic [BIT_W-1:0]  cnt, cnt_n;
  logic [PRE_W-1:0]  pre_cnt, pre_cnt_n;
  logic [1:0]        op, op_n;
  logic [REG_AW-1:0] phyad, phyad_n;
  logic [REG_AW-1:0] regad, regad_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              mdio_n, oe_n;
  logic              commit_c;
  logic              rd_match_c, wr_match_c;
  logic [REG_AW-1:0] rd_idx_c;
  logic [DATA_W-1:0] rd_data_c;
  mdio_wr_t          wr_c;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              soft_rst_c;

  assign rd_match_c = (op == OP_READ) && (phyad == PHY_ADDR);
`ifdef MDIO_RESP_BROADCAST_EN
  assign wr_match_c = (op == OP_WRITE) && ((phyad == PHY_ADDR) || (phyad == 5'h00));
`else
  assign wr_match_c = (op == OP_WRITE) && (phyad == PHY_ADDR);
`endif

  // Register index completed by the current (final) REGAD sample
  assign rd_idx_c = {regad[REG_AW-2:0], mdio_s};
  assign wr_c     = mdio_wr_t'({regad, shreg[DATA_W-2:0], mdio_s});
  assign soft_rst_c = regs[REG_BMCR][15];

  always_comb begin
    case (rd_idx_c)
      REG_BMSR: rd_data_c = BMSR_BASE | {13'b0, i_link_up, 2'b0};
      REG_ID1:  rd_data_c = PHY_ID1;
      REG_ID2:  rd_data_c = PHY_ID2;
      default:  rd_data_c = regs[rd_idx_c];
    endcase
  end

  // Frame decoder: MDIO sampled on MDC rise, driven on MDC fall
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pre_cnt_n = pre_cnt;
    op_n      = op;
    phyad_n   = phyad;
    regad_n   = regad;
    shreg_n   = shreg;
    mdio_n    = o_mdio;
    oe_n      = oe_mdio;
    commit_c  = 1'b0;
    case (state)
      S_PRE: begin
        if (mdc_rise) begin
          if (mdio_s) begin
            if (pre_cnt != '1) pre_cnt_n = pre_cnt + 6'd1;
          end else begin
            if (pre_cnt >= 6'(PRE_LEN)) state_n = S_ST;
            pre_cnt_n = '0;
          end
        end
      end
      S_ST: begin
        if (mdc_rise) begin
          cnt_n   = '0;
          state_n = mdio_s ? S_OP : S_PRE;
        end
      end
      S_OP: begin
        if (mdc_rise) begin
          op_n = {op[0], mdio_s};
          if (cnt == 5'd1) begin
            cnt_n   = '0;
            state_n = ((op_n == OP_READ) || (op_n == OP_WRITE)) ? S_PHYAD : S_PRE;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
      end
      S_PHYAD: begin
        if (mdc_rise) begin
          phyad_n = {phyad[REG_AW-2:0], mdio_s};
          if (cnt == 5'd4) begin
            cnt_n   = '0;
            state_n = S_REGAD;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
      end
      S_REGAD: begin
        if (mdc_rise) begin
          regad_n = rd_idx_c;
          if (cnt == 5'd4) begin
            cnt_n   = '0;
            shreg_n = rd_data_c;
            state_n = S_TA;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
      end
      S_TA: begin
        if (mdc_rise) begin
          if ((op == OP_WRITE) && (((cnt == 5'd0) && !mdio_s) || ((cnt == 5'd1) && mdio_s))) begin
            cnt_n   = '0;
            state_n = S_PRE;
          end else if (cnt == 5'd1) begin
            cnt_n   = '0;
            state_n = S_DATA;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end else if (mdc_fall && rd_match_c && (cnt == 5'd1)) begin
          oe_n   = 1'b1;
          mdio_n = 1'b0;
        end
      end
      S_DATA: begin
        if (op == OP_WRITE) begin
          if (mdc_rise) begin
            shreg_n = {shreg[DATA_W-2:0], mdio_s};
            if (cnt == 5'd15) begin
              commit_c = wr_match_c;
              cnt_n    = '0;
              state_n  = S_PRE;
            end else begin
              cnt_n = cnt + 5'd1;
            end
          end
        end else begin
          if (mdc_rise && (cnt != 5'd16)) begin
            cnt_n = cnt + 5'd1;
          end else if (mdc_fall) begin
            if (cnt == 5'd16) begin
              oe_n      = 1'b0;
              mdio_n    = 1'b0;
              cnt_n     = '0;
              pre_cnt_n = '0;
              state_n   = S_PRE;
            end else if (rd_match_c) begin
              mdio_n  = shreg[DATA_W-1];
              shreg_n = {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_n = S_PRE;
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_PRE;
      cnt     <= '0;
      pre_cnt <= '0;
      op      <= '0;
      phyad   <= '0;
      regad   <= '0;
      shreg   <= '0;
      o_mdio  <= 1'b0;
      oe_mdio <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pre_cnt <= pre_cnt_n;
      op      <= op_n;
      phyad   <= phyad_n;
      regad   <= regad_n;
      shreg   <= shreg_n;
      o_mdio  <= mdio_n;
      oe_mdio <= oe_n;
    end
  end

  // Commit reporting; address/data hold until the next commit
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
    end else begin
      o_wr_strobe <= commit_c;
      if (commit_c) begin
        o_wr_addr <= wr_c.addr;
        o_wr_data <= wr_c.data;
      end
    end
  end

  // Register file; BMCR bit 15 reloads defaults on the cycle after it lands
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= reg_reset_val(5'(i));
    end else if (soft_rst_c) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= reg_reset_val(5'(i));
    end else if (commit_c && reg_writable(wr_c.addr)) begin
      regs[wr_c.addr] <= wr_c.data;
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench: bit-bangs Clause 22 frames at the responder and checks replies.
module tb_mdio_responder;
  import mdio_pkg::*;

  localparam int unsigned HALF = 8;

  logic        msoc_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_mdc = 1'b0;
  logic        i_link_up = 1'b0;
  logic        mac_oe = 1'b0;
  logic        mac_d = 1'b1;
  logic        mdio_bus;
  logic        o_mdio, oe_mdio, o_wr_strobe;
  logic [4:0]  o_wr_addr;
  logic [15:0] o_wr_data;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  logic [15:0] f_rd;
  int          f_oe_bits;
  logic        f_ta1_oe, f_ta2_bus, f_oe_before, f_oe_after;

  // Open-drain style bus with pull-up; the responder wins when it drives
  assign mdio_bus = oe_mdio ? o_mdio : (mac_oe ? mac_d : 1'b1);

  mdio_responder dut (
    .msoc_clk    (msoc_clk),
    .rstn        (rstn),
    .i_mdc       (i_mdc),
    .i_mdio      (mdio_bus),
    .o_mdio      (o_mdio),
    .oe_mdio     (oe_mdio),
    .i_link_up   (i_link_up),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data)
  );

  always #5 msoc_clk = ~msoc_clk;

  always @(negedge msoc_clk) begin
    if (o_wr_strobe) begin
      strobe_cnt = strobe_cnt + 1;
      last_addr  = o_wr_addr;
      last_data  = o_wr_data;
    end
  end

  // One full frame; abort_at >= 0 asserts reset in the low phase of that bit
  task automatic run_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] ra, input logic [15:0] wd, input int abort_at);
    logic bits[$];
    logic drv[$];
    int   base;
    for (int k = 0; k < pre_len; k++) begin bits.push_back(1'b1); drv.push_back(1'b1); end
    bits.push_back(1'b0); drv.push_back(1'b1);
    bits.push_back(1'b1); drv.push_back(1'b1);
    for (int k = 1; k >= 0; k--) begin bits.push_back(op[k]); drv.push_back(1'b1); end
    for (int k = 4; k >= 0; k--) begin bits.push_back(phy[k]); drv.push_back(1'b1); end
    for (int k = 4; k >= 0; k--) begin bits.push_back(ra[k]); drv.push_back(1'b1); end
    if (op == OP_WRITE) begin
      bits.push_back(1'b1); drv.push_back(1'b1);
      bits.push_back(1'b0); drv.push_back(1'b1);
      for (int k = 15; k >= 0; k--) begin bits.push_back(wd[k]); drv.push_back(1'b1); end
    end else begin
      for (int k = 0; k < 18; k++) begin bits.push_back(1'b1); drv.push_back(1'b0); end
    end
    bits.push_back(1'b1); drv.push_back(1'b0);
    bits.push_back(1'b0); drv.push_back(1'b1);
    f_rd = '0; f_oe_bits = 0; f_ta1_oe = 1'bx; f_ta2_bus = 1'bx;
    base = pre_len + 14;
    for (int i = 0; i < bits.size(); i++) begin
      mac_oe = drv[i];
      mac_d  = bits[i];
      repeat (HALF) @(posedge msoc_clk);
      #1;
      if (i == abort_at) begin
        f_oe_before = oe_mdio;
        rstn = 1'b0;
        #1;
        f_oe_after = oe_mdio;
        mac_oe = 1'b0;
        return;
      end
      if (oe_mdio) f_oe_bits++;
      if (i == base) f_ta1_oe = oe_mdio;
      if (i == base + 1) f_ta2_bus = mdio_bus;
      if (i >= base + 2 && i <= base + 17) f_rd = {f_rd[14:0], mdio_bus};
      i_mdc = 1'b1;
      repeat (HALF) @(posedge msoc_clk);
      #1;
      i_mdc = 1'b0;
    end
    mac_oe = 1'b0;
  endtask

  task automatic test_reset;
    repeat (4) @(posedge msoc_clk);
    #1;
    total++; if (oe_mdio !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", oe_mdio); end
    total++; if (o_mdio !== 1'b0) begin bad++; $display("FAIL reset_mdio: got %b want 0", o_mdio); end
    total++; if (o_wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", o_wr_strobe); end
    total++; if (o_wr_addr !== 5'd0) begin bad++; $display("FAIL reset_addr: got %h want 00", o_wr_addr); end
    total++; if (o_wr_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", o_wr_data); end
    rstn = 1'b1;
    repeat (4) @(posedge msoc_clk);
  endtask

  task automatic test_read_id;
    run_frame(32, OP_READ, 5'h01, 5'd2, 16'h0, -1);
    total++; if (f_rd !== 16'h0007) begin bad++; $display("FAIL read_id1: got %h want 0007", f_rd); end
    total++; if (f_oe_bits != 17) begin bad++; $display("FAIL read_oe_bits: got %0d want 17", f_oe_bits); end
    total++; if (f_ta1_oe !== 1'b0) begin bad++; $display("FAIL read_ta1_release: got %b want 0", f_ta1_oe); end
    total++; if (f_ta2_bus !== 1'b0) begin bad++; $display("FAIL read_ta2_zero: got %b want 0", f_ta2_bus); end
    run_frame(32, OP_READ, 5'h01, 5'd3, 16'h0, -1);
    total++; if (f_rd !== 16'hC0F1) begin bad++; $display("FAIL read_id2: got %h want c0f1", f_rd); end
    run_frame(32, OP_READ, 5'h01, 5'd0, 16'h0, -1);
    total++; if (f_rd !== 16'h3100) begin bad++; $display("FAIL read_bmcr: got %h want 3100", f_rd); end
    run_frame(32, OP_READ, 5'h01, 5'd1, 16'h0, -1);
    total++; if (f_rd !== 16'h7809) begin bad++; $display("FAIL read_bmsr_down: got %h want 7809", f_rd); end
  endtask

  task automatic test_write_read;
    int s0;
    s0 = strobe_cnt;
    run_frame(32, OP_WRITE, 5'h01, 5'd4, 16'hA5A5, -1);
    total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL wr_strobe_cnt: got %0d want 1", strobe_cnt - s0); end
    total++; if (last_addr !== 5'd4) begin bad++; $display("FAIL wr_addr: got %h want 04", last_addr); end
    total++; if (last_data !== 16'hA5A5) begin bad++; $display("FAIL wr_data: got %h want a5a5", last_data); end
    total++; if (o_wr_data !== 16'hA5A5) begin bad++; $display("FAIL wr_data_hold: got %h want a5a5", o_wr_data); end
    run_frame(32, OP_READ, 5'h01, 5'd4, 16'h0, -1);
    total++; if (f_rd !== 16'hA5A5) begin bad++; $display("FAIL wr_readback: got %h want a5a5", f_rd); end
  endtask

  task automatic test_short_preamble;
    run_frame(31, OP_READ, 5'h01, 5'd2, 16'h0, -1);
    total++; if (f_oe_bits != 0) begin bad++; $display("FAIL short_pre_oe: got %0d want 0", f_oe_bits); end
    run_frame(32, OP_READ, 5'h01, 5'd3, 16'h0, -1);
    total++; if (f_rd !== 16'hC0F1) begin bad++; $display("FAIL short_pre_recover: got %h want c0f1", f_rd); end
  endtask

  task automatic test_bad_phyad;
    run_frame(32, OP_READ, 5'h05, 5'd2, 16'h0, -1);
    total++; if (f_oe_bits != 0) begin bad++; $display("FAIL bad_phy_oe: got %0d want 0", f_oe_bits); end
    total++; if (dut.state !== S_PRE) begin bad++; $display("FAIL bad_phy_state: got %0d want %0d", dut.state, S_PRE); end
  endtask

  task automatic test_read_only_write;
    int s0;
    s0 = strobe_cnt;
    run_frame(32, OP_WRITE, 5'h01, 5'd2, 16'hFFFF, -1);
    total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL ro_strobe_cnt: got %0d want 1", strobe_cnt - s0); end
    run_frame(32, OP_READ, 5'h01, 5'd2, 16'h0, -1);
    total++; if (f_rd !== 16'h0007) begin bad++; $display("FAIL ro_unchanged: got %h want 0007", f_rd); end
  endtask

  task automatic test_broadcast;
    int s0;
    int exp_cnt;
    logic [15:0] exp_rd;
`ifdef MDIO_RESP_BROADCAST_EN
    exp_cnt = 1; exp_rd = 16'h55AA;
`else
    exp_cnt = 0; exp_rd = 16'h0000;
`endif
    s0 = strobe_cnt;
    run_frame(32, OP_WRITE, 5'h00, 5'd5, 16'h55AA, -1);
    total++; if (strobe_cnt - s0 != exp_cnt) begin bad++; $display("FAIL bcast_strobe: got %0d want %0d", strobe_cnt - s0, exp_cnt); end
    run_frame(32, OP_READ, 5'h01, 5'd5, 16'h0, -1);
    total++; if (f_rd !== exp_rd) begin bad++; $display("FAIL bcast_readback: got %h want %h", f_rd, exp_rd); end
  endtask

  task automatic test_soft_reset;
    run_frame(32, OP_WRITE, 5'h01, 5'd4, 16'h1234, -1);
    run_frame(32, OP_WRITE, 5'h01, 5'd0, 16'h8000, -1);
    total++; if (last_data !== 16'h8000 || last_addr !== 5'd0) begin
      bad++; $display("FAIL srst_commit: got %h@%h want 8000@00", last_data, last_addr);
    end
    run_frame(32, OP_READ, 5'h01, 5'd0, 16'h0, -1);
    total++; if (f_rd !== 16'h3100) begin bad++; $display("FAIL srst_bmcr: got %h want 3100", f_rd); end
    run_frame(32, OP_READ, 5'h01, 5'd4, 16'h0, -1);
    total++; if (f_rd !== 16'h0000) begin bad++; $display("FAIL srst_reg4: got %h want 0000", f_rd); end
  endtask

  task automatic test_reset_mid_data;
    run_frame(32, OP_WRITE, 5'h01, 5'd4, 16'hBEEF, -1);
    run_frame(32, OP_READ, 5'h01, 5'd2, 16'h0, 32 + 14 + 7);
    total++; if (f_oe_before !== 1'b1) begin bad++; $display("FAIL midrst_oe_before: got %b want 1", f_oe_before); end
    total++; if (f_oe_after !== 1'b0) begin bad++; $display("FAIL midrst_oe_after: got %b want 0", f_oe_after); end
    repeat (4) @(posedge msoc_clk);
    #1;
    rstn = 1'b1;
    i_link_up = 1'b1;
    repeat (4) @(posedge msoc_clk);
    run_frame(32, OP_READ, 5'h01, 5'd1, 16'h0, -1);
    total++; if (f_rd !== 16'h780D) begin bad++; $display("FAIL midrst_bmsr_up: got %h want 780d", f_rd); end
    total++; if (f_oe_bits != 17) begin bad++; $display("FAIL midrst_oe_bits: got %0d want 17", f_oe_bits); end
    run_frame(32, OP_READ, 5'h01, 5'd4, 16'h0, -1);
    total++; if (f_rd !== 16'h0000) begin bad++; $display("FAIL midrst_reg4: got %h want 0000", f_rd); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_read();
    test_short_preamble();
    test_bad_phyad();
    test_read_only_write();
    test_broadcast();
    test_soft_reset();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
